// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and ALU encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluctl_t;

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - maps ALUOp plus instruction fields to the ALU control code
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type sub from I-type addi with imm[10] set
                    3'b000:  alu_control = (funct7b5 && op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM controller for a multicycle RISC-V datapath (option: MC_WAITSTATE_EN)
module multicycle_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
`ifdef MC_WAITSTATE_EN
    input  logic       mem_ready,
`endif
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       instr_done,
    output logic       illegal
);

    state_t     state_q, state_d;
    logic       mem_ok;
    logic       pc_update, branch, ir_write, reg_write, mem_write;
    logic       done_s, illegal_s;
    logic [1:0] alu_op;

`ifdef MC_WAITSTATE_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        done_s    = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = mem_ok;
                pc_update = mem_ok;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ok) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                        done_s    = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ok) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                done_s    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = mem_ok;
                done_s    = mem_ok;
                if (mem_ok) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                done_s    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                done_s  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are masked by reset_n so they drop in the same cycle reset asserts
    assign PCWrite    = reset_n & (pc_update | (branch & Zero));
    assign IRWrite    = reset_n & ir_write;
    assign RegWrite   = reset_n & reg_write;
    assign MemWrite   = reset_n & mem_write;
    assign instr_done = reset_n & done_s;
    assign illegal    = reset_n & illegal_s;

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    mc_aludec u_aludec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       instr_done, illegal;
`ifdef MC_WAITSTATE_EN
    logic       mem_ready;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
`ifdef MC_WAITSTATE_EN
        .mem_ready  (mem_ready),
`endif
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .instr_done (instr_done),
        .illegal    (illegal)
    );

    // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,instr_done,illegal}
    logic [12:0] ctrl;
    assign ctrl = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ResultSrc,
                   ALUSrcA, ALUSrcB, instr_done, illegal};

    localparam logic [12:0] V_FETCH   = 13'b1_1_0_0_0_10_00_10_0_0;
    localparam logic [12:0] V_FETCH_Z = 13'b0_0_0_0_0_10_00_10_0_0;
    localparam logic [12:0] V_DECODE  = 13'b0_0_0_0_0_00_01_01_0_0;
    localparam logic [12:0] V_DEC_ILL = 13'b0_0_0_0_0_00_01_01_1_1;
    localparam logic [12:0] V_MEMADR  = 13'b0_0_0_0_0_00_10_01_0_0;
    localparam logic [12:0] V_MEMREAD = 13'b0_0_0_0_1_00_00_00_0_0;
    localparam logic [12:0] V_MEMWB   = 13'b0_0_1_0_0_01_00_00_1_0;
    localparam logic [12:0] V_MEMWR   = 13'b0_0_0_1_1_00_00_00_1_0;
    localparam logic [12:0] V_EXECR   = 13'b0_0_0_0_0_00_10_00_0_0;
    localparam logic [12:0] V_EXECI   = 13'b0_0_0_0_0_00_10_01_0_0;
    localparam logic [12:0] V_ALUWB   = 13'b0_0_1_0_0_00_00_00_1_0;
    localparam logic [12:0] V_BEQ_T   = 13'b1_0_0_0_0_00_10_00_1_0;
    localparam logic [12:0] V_BEQ_N   = 13'b0_0_0_0_0_00_10_00_1_0;
    localparam logic [12:0] V_JAL     = 13'b1_0_0_0_0_00_01_10_0_0;
`ifdef MC_WAITSTATE_EN
    localparam logic [12:0] V_MEMWR_W = 13'b0_0_0_0_1_00_00_00_0_0;
`endif

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH.
    task automatic run(input string tag, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic z, input int n,
                       input logic [12:0] e1, input logic [12:0] e2,
                       input logic [12:0] e3, input logic [12:0] e4,
                       input int alu_cyc, input logic [2:0] alu_exp,
                       input logic [1:0] imm_exp);
        logic [12:0] ev [5];
        ev = '{V_FETCH, e1, e2, e3, e4};
        for (int i = 0; i < n; i++) begin
            op = o; funct3 = f3; funct7b5 = f7; Zero = z;
            #1;
            check_eq($sformatf("%s_c%0d", tag, i), {3'b0, ctrl}, {3'b0, ev[i]});
            if (i == alu_cyc)
                check_eq($sformatf("%s_alu", tag), {13'b0, ALUControl}, {13'b0, alu_exp});
            if (i == 0)
                check_eq($sformatf("%s_imm", tag), {14'b0, ImmSrc}, {14'b0, imm_exp});
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0;
`ifdef MC_WAITSTATE_EN
        mem_ready = 1'b1;
`endif
        @(negedge clk);
        #1;
        check_eq("reset_vec", {3'b0, ctrl}, {3'b0, V_FETCH_Z});
        reset_n = 1'b1;

        run("lw",   7'b0000011, 3'b010, 1'b0, 1'b1, 5, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, 2, 3'b000, 2'b00);
        run("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4, V_DECODE, V_MEMADR, V_MEMWR, 13'b0, 2, 3'b000, 2'b01);
        run("sub",  7'b0110011, 3'b000, 1'b1, 1'b1, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b001, 2'b00);
        run("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, V_DECODE, V_EXECI, V_ALUWB, 13'b0, 2, 3'b000, 2'b00);
        run("add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b000, 2'b00);
        run("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b101, 2'b00);
        run("or",   7'b0110011, 3'b110, 1'b0, 1'b0, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b011, 2'b00);
        run("andi", 7'b0010011, 3'b111, 1'b0, 1'b0, 4, V_DECODE, V_EXECI, V_ALUWB, 13'b0, 2, 3'b010, 2'b00);
        run("xor",  7'b0110011, 3'b100, 1'b0, 1'b0, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b000, 2'b00);
        run("beqT", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, V_DECODE, V_BEQ_T, 13'b0, 13'b0, 2, 3'b001, 2'b10);
        run("beqN", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, V_DECODE, V_BEQ_N, 13'b0, 13'b0, 2, 3'b001, 2'b10);
        run("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, V_DECODE, V_JAL, V_ALUWB, 13'b0, 2, 3'b000, 2'b11);
        run("ill",  7'b1111111, 3'b000, 1'b0, 1'b0, 2, V_DEC_ILL, 13'b0, 13'b0, 13'b0, 1, 3'b000, 2'b00);
        run("post_ill", 7'b0010011, 3'b110, 1'b0, 1'b0, 4, V_DECODE, V_EXECI, V_ALUWB, 13'b0, 2, 3'b011, 2'b00);

        // sw aborted by reset while in MEMWRITE
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_pre_memwr", {3'b0, ctrl}, {3'b0, V_MEMWR});
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_in_memwr", {3'b0, ctrl}, {3'b0, V_FETCH_Z});
        @(negedge clk);
        reset_n = 1'b1;
        run("after_rst", 7'b0110011, 3'b111, 1'b0, 1'b0, 4, V_DECODE, V_EXECR, V_ALUWB, 13'b0, 2, 3'b010, 2'b00);

`ifdef MC_WAITSTATE_EN
        mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_eq($sformatf("fetch_wait%0d", k), {3'b0, ctrl}, {3'b0, V_FETCH_Z});
            @(negedge clk);
        end
        mem_ready = 1'b1;
        op = 7'b0100011;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("memwr_wait%0d", k), {3'b0, ctrl}, {3'b0, V_MEMWR_W});
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check_eq("memwr_ready", {3'b0, ctrl}, {3'b0, V_MEMWR});
        @(negedge clk);
        run("ws_after", 7'b0000011, 3'b010, 1'b0, 1'b0, 5, V_DECODE, V_MEMADR, V_MEMREAD, V_MEMWB, 2, 3'b000, 2'b00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
